// File: rtl/cpu_pmp.sv
// Physical Memory Protection unit: software-writable pmpcfg/pmpaddr table with registered CSR reads
// and NUM_PORTS registered permission lookups. NAPOT matching is built only with CPU_PMP_NAPOT_EN.
module cpu_pmp #(
    parameter int         NUM_ENTRIES = 16,
    parameter int         NUM_PORTS   = 2,
    parameter logic [2:0] DEFAULT_RWX = 3'b111
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [11:0]            read_addr_i,
    input  logic                   read_enable_i,
    output logic [31:0]            read_data_o,
    input  logic [11:0]            write_addr_i,
    input  logic [31:0]            write_data_i,
    input  logic                   write_enable_i,
    input  logic [32*NUM_PORTS-1:0] lookup_addr_i,
    input  logic [NUM_PORTS-1:0]   lookup_valid_i,
    output logic [3*NUM_PORTS-1:0] lookup_rwx_o,
    output logic [NUM_PORTS-1:0]   lookup_valid_o,
    output logic [5*NUM_PORTS-1:0] lookup_entry_o
);

    typedef enum logic [1:0] {
        A_OFF   = 2'd0,
        A_TOR   = 2'd1,
        A_NA4   = 2'd2,
        A_NAPOT = 2'd3
    } pmpMode_e;

    localparam logic [4:0] NO_ENTRY = 5'h1F;

    // The table is always 16 deep; entries at or above NUM_ENTRIES are never written and stay OFF.
    logic [7:0]  cfg_q     [16];
    logic [7:0]  cfg_d     [16];
    logic [31:0] pmpAddr_q [16];
    logic [31:0] pmpAddr_d [16];

    logic [31:0]            readData_q;
    logic [31:0]            readData_d;
    logic [NUM_PORTS-1:0]   lookupValid_q;
    logic [3*NUM_PORTS-1:0] lookupRwx_q;
    logic [3*NUM_PORTS-1:0] lookupRwx_d;
    logic [5*NUM_PORTS-1:0] lookupEntry_q;
    logic [5*NUM_PORTS-1:0] lookupEntry_d;

    logic cfgWrite;
    logic addrWrite;
    logic cfgRead;
    logic addrRead;

    assign cfgWrite  = write_enable_i && (write_addr_i[11:2] == 10'h0E8);
    assign addrWrite = write_enable_i && (write_addr_i[11:4] == 8'h3B);
    assign cfgRead   = (read_addr_i[11:2] == 10'h0E8);
    assign addrRead  = (read_addr_i[11:4] == 8'h3B);

    function automatic logic [7:0] legalizeCfg(input logic [7:0] raw);
        logic [1:0] mode;
        mode = raw[4:3];
`ifndef CPU_PMP_NAPOT_EN
        if (mode == A_NAPOT) begin
            mode = A_OFF;
        end
`endif
        return {raw[7], 2'b00, mode, raw[2], raw[1] & raw[0], raw[0]};
    endfunction

    // A locked TOR entry also freezes the pmpaddr below it, since that address is its lower bound.
    logic [15:0] addrLocked;
    for (genvar i = 0; i < 16; i++) begin : gLock
        if (i + 1 < NUM_ENTRIES) begin : gWithNext
            assign addrLocked[i] = cfg_q[i][7] | (cfg_q[i+1][7] & (cfg_q[i+1][4:3] == A_TOR));
        end else begin : gLast
            assign addrLocked[i] = cfg_q[i][7];
        end
    end

    always_comb begin
        cfg_d     = cfg_q;
        pmpAddr_d = pmpAddr_q;
        for (int i = 0; i < 16; i++) begin
            if (i < NUM_ENTRIES) begin
                if (cfgWrite && (write_addr_i[1:0] == i[3:2]) && !cfg_q[i][7]) begin
                    cfg_d[i] = legalizeCfg(write_data_i[{i[1:0], 3'b000} +: 8]);
                end
                if (addrWrite && (write_addr_i[3:0] == i[3:0]) && !addrLocked[i]) begin
                    pmpAddr_d[i] = write_data_i;
                end
            end
        end
    end

    always_comb begin
        readData_d = '0;
        if (read_enable_i) begin
            for (int i = 0; i < 16; i++) begin
                if (i < NUM_ENTRIES) begin
                    if (cfgRead && (read_addr_i[1:0] == i[3:2])) begin
                        readData_d[{i[1:0], 3'b000} +: 8] = cfg_q[i];
                    end
                    if (addrRead && (read_addr_i[3:0] == i[3:0])) begin
                        readData_d = pmpAddr_q[i];
                    end
                end
            end
        end
    end

    logic [31:0] torLower [NUM_ENTRIES];
`ifdef CPU_PMP_NAPOT_EN
    logic [31:0] napotMask [NUM_ENTRIES];
`endif
    for (genvar e = 0; e < NUM_ENTRIES; e++) begin : gEntry
        if (e == 0) begin : gFirst
            assign torLower[e] = '0;
        end else begin : gRest
            assign torLower[e] = pmpAddr_q[e-1];
        end
`ifdef CPU_PMP_NAPOT_EN
        assign napotMask[e] = pmpAddr_q[e] ^ (pmpAddr_q[e] + 32'd1);
`endif
    end

    // Byte offset bits never take part in matching; the table works in 4-byte words.
    logic [2*NUM_PORTS-1:0] unusedAddrBits;
    logic [NUM_PORTS*NUM_ENTRIES-1:0] entryHit;
    for (genvar p = 0; p < NUM_PORTS; p++) begin : gPort
        logic [31:0] wordAddr;
        assign wordAddr = {2'b00, lookup_addr_i[32*p+2 +: 30]};
        assign unusedAddrBits[2*p +: 2] = lookup_addr_i[32*p +: 2];
        for (genvar e = 0; e < NUM_ENTRIES; e++) begin : gCmp
            logic torHit;
            logic na4Hit;
            logic napotHit;
            assign torHit = (cfg_q[e][4:3] == A_TOR) && (wordAddr >= torLower[e])
                            && (wordAddr < pmpAddr_q[e]);
            assign na4Hit = (cfg_q[e][4:3] == A_NA4) && (wordAddr == pmpAddr_q[e]);
`ifdef CPU_PMP_NAPOT_EN
            assign napotHit = (cfg_q[e][4:3] == A_NAPOT)
                              && (((wordAddr ^ pmpAddr_q[e]) & ~napotMask[e]) == 32'd0);
`else
            assign napotHit = 1'b0;
`endif
            assign entryHit[p*NUM_ENTRIES+e] = torHit | na4Hit | napotHit;
        end
    end

    // Scan from the top so the lowest-indexed hit is the one left standing.
    always_comb begin
        lookupRwx_d   = '0;
        lookupEntry_d = {NUM_PORTS{NO_ENTRY}};
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (lookup_valid_i[p]) begin
                lookupRwx_d[3*p +: 3] = DEFAULT_RWX;
                for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
                    if (entryHit[p*NUM_ENTRIES+e]) begin
                        lookupRwx_d[3*p +: 3]   = {cfg_q[e][0], cfg_q[e][1], cfg_q[e][2]};
                        lookupEntry_d[5*p +: 5] = e[4:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 16; i++) begin
                cfg_q[i]     <= '0;
                pmpAddr_q[i] <= '0;
            end
            readData_q    <= '0;
            lookupValid_q <= '0;
            lookupRwx_q   <= '0;
            lookupEntry_q <= {NUM_PORTS{NO_ENTRY}};
        end else begin
            cfg_q         <= cfg_d;
            pmpAddr_q     <= pmpAddr_d;
            readData_q    <= readData_d;
            lookupValid_q <= lookup_valid_i;
            lookupRwx_q   <= lookupRwx_d;
            lookupEntry_q <= lookupEntry_d;
        end
    end

    assign read_data_o    = readData_q;
    assign lookup_valid_o = lookupValid_q;
    assign lookup_rwx_o   = lookupRwx_q;
    assign lookup_entry_o = lookupEntry_q;

endmodule

// File: tb/tb_cpu_pmp.sv
// Self-checking bench for cpu_pmp: directed scenarios plus randomized traffic against a
// range-based reference model of the PMP table (honours CPU_PMP_NAPOT_EN like the design).
module tb_cpu_pmp;

    localparam int NE = 14;
    localparam int NP = 2;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic [11:0]    read_addr_i;
    logic           read_enable_i;
    logic [31:0]    read_data_o;
    logic [11:0]    write_addr_i;
    logic [31:0]    write_data_i;
    logic           write_enable_i;
    logic [32*NP-1:0] lookup_addr_i;
    logic [NP-1:0]  lookup_valid_i;
    logic [3*NP-1:0] lookup_rwx_o;
    logic [NP-1:0]  lookup_valid_o;
    logic [5*NP-1:0] lookup_entry_o;

    int testsRun = 0;
    int testsFailed = 0;

    logic [7:0]  mCfg  [16];
    logic [31:0] mAddr [16];

    always #5 clk_i = ~clk_i;

    cpu_pmp #(
        .NUM_ENTRIES(NE),
        .NUM_PORTS(NP),
        .DEFAULT_RWX(3'b111)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .read_addr_i(read_addr_i),
        .read_enable_i(read_enable_i),
        .read_data_o(read_data_o),
        .write_addr_i(write_addr_i),
        .write_data_i(write_data_i),
        .write_enable_i(write_enable_i),
        .lookup_addr_i(lookup_addr_i),
        .lookup_valid_i(lookup_valid_i),
        .lookup_rwx_o(lookup_rwx_o),
        .lookup_valid_o(lookup_valid_o),
        .lookup_entry_o(lookup_entry_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] modelLegal(input logic [7:0] raw);
        logic [7:0] v;
        v = raw & 8'h9F;
        if (v[1] && !v[0]) v[1] = 1'b0;
`ifndef CPU_PMP_NAPOT_EN
        if (v[4:3] == 2'd3) v[4:3] = 2'd0;
`endif
        return v;
    endfunction

    function automatic logic napotCovers(input logic [31:0] pa, input logic [31:0] a);
        int t;
        longint unsigned size;
        longint unsigned base;
        t = 0;
        while (t < 32 && pa[t]) t++;
        if (t == 32) return 1'b1;
        size = 64'd1 << (t + 1);
        base = {32'd0, pa} & ~(size - 64'd1);
        return ({32'd0, a} >= base) && ({32'd0, a} < base + size);
    endfunction

    function automatic logic [31:0] modelRead(input logic [11:0] addr);
        logic [31:0] r;
        int idx;
        r = '0;
        if (addr >= 12'h3A0 && addr <= 12'h3A3) begin
            for (int b = 0; b < 4; b++) begin
                idx = int'(addr - 12'h3A0) * 4 + b;
                if (idx < NE) r[8*b +: 8] = mCfg[idx];
            end
        end else if (addr >= 12'h3B0 && addr <= 12'h3BF) begin
            idx = int'(addr - 12'h3B0);
            if (idx < NE) r = mAddr[idx];
        end
        return r;
    endfunction

    task automatic modelWrite(input logic [11:0] addr, input logic [31:0] data);
        int idx;
        logic locked;
        if (addr >= 12'h3A0 && addr <= 12'h3A3) begin
            for (int b = 0; b < 4; b++) begin
                idx = int'(addr - 12'h3A0) * 4 + b;
                if (idx < NE && !mCfg[idx][7]) mCfg[idx] = modelLegal(data[8*b +: 8]);
            end
        end else if (addr >= 12'h3B0 && addr <= 12'h3BF) begin
            idx = int'(addr - 12'h3B0);
            if (idx < NE) begin
                locked = mCfg[idx][7];
                if (idx + 1 < NE && mCfg[idx+1][7] && mCfg[idx+1][4:3] == 2'd1) locked = 1'b1;
                if (!locked) mAddr[idx] = data;
            end
        end
    endtask

    task automatic modelLookup(input logic [31:0] byteAddr, output logic [2:0] rwx, output logic [4:0] entry);
        logic [31:0] a;
        logic [31:0] lo;
        logic hit;
        a = byteAddr >> 2;
        rwx = 3'b111;
        entry = 5'h1F;
        for (int i = NE - 1; i >= 0; i--) begin
            hit = 1'b0;
            lo = (i == 0) ? 32'd0 : mAddr[(i == 0) ? 0 : i - 1];
            case (mCfg[i][4:3])
                2'd1: hit = (lo <= a) && (a < mAddr[i]);
                2'd2: hit = (a == mAddr[i]);
                2'd3: hit = napotCovers(mAddr[i], a);
                default: hit = 1'b0;
            endcase
            if (hit) begin
                rwx = {mCfg[i][0], mCfg[i][1], mCfg[i][2]};
                entry = i[4:0];
            end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic rdEn, input logic [11:0] rdAddr,
                                 input logic wrEn, input logic [11:0] wrAddr, input logic [31:0] wrData,
                                 input logic [NP-1:0] lv, input logic [31:0] la0, input logic [31:0] la1);
        logic [31:0] expRead;
        logic [NP-1:0] expValid;
        logic [2:0] expRwx [NP];
        logic [4:0] expEntry [NP];
        logic [31:0] la [NP];
        la[0] = la0;
        la[1] = la1;
        reset_i = rst;
        read_enable_i = rdEn;
        read_addr_i = rdAddr;
        write_enable_i = wrEn;
        write_addr_i = wrAddr;
        write_data_i = wrData;
        lookup_valid_i = lv;
        lookup_addr_i = {la1, la0};
        @(posedge clk_i);
        if (rst) begin
            expRead = '0;
            expValid = '0;
            for (int p = 0; p < NP; p++) begin
                expRwx[p] = 3'b000;
                expEntry[p] = 5'h1F;
            end
            for (int i = 0; i < 16; i++) begin
                mCfg[i] = '0;
                mAddr[i] = '0;
            end
        end else begin
            expRead = rdEn ? modelRead(rdAddr) : 32'd0;
            expValid = lv;
            for (int p = 0; p < NP; p++) begin
                if (lv[p]) begin
                    modelLookup(la[p], expRwx[p], expEntry[p]);
                end else begin
                    expRwx[p] = 3'b000;
                    expEntry[p] = 5'h1F;
                end
            end
            if (wrEn) modelWrite(wrAddr, wrData);
        end
        #1;
        checkOutput("readData", read_data_o, expRead);
        for (int p = 0; p < NP; p++) begin
            checkOutput($sformatf("valid%0d", p), {31'd0, lookup_valid_o[p]}, {31'd0, expValid[p]});
            checkOutput($sformatf("rwx%0d", p), {29'd0, lookup_rwx_o[3*p +: 3]}, {29'd0, expRwx[p]});
            checkOutput($sformatf("entry%0d", p), {27'd0, lookup_entry_o[5*p +: 5]}, {27'd0, expEntry[p]});
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b1, 12'h3A0, 1'b1, 12'h3A0, 32'hFFFF_FFFF, 2'b11, 32'h0, 32'h4);
    endtask

    task automatic doWrite(input logic [11:0] addr, input logic [31:0] data);
        applyStimulus(1'b0, 1'b0, 12'h0, 1'b1, addr, data, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic doRead(input logic [11:0] addr);
        applyStimulus(1'b0, 1'b1, addr, 1'b0, 12'h0, 32'h0, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic doLookup(input logic [NP-1:0] lv, input logic [31:0] la0, input logic [31:0] la1);
        applyStimulus(1'b0, 1'b0, 12'h0, 1'b0, 12'h0, 32'h0, lv, la0, la1);
    endtask

    function automatic logic [11:0] randCsrAddr();
        case ($urandom_range(0, 2))
            0: return 12'h3A0 + 12'($urandom_range(0, 3));
            1: return 12'h3B0 + 12'($urandom_range(0, 15));
            default: return 12'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] randWriteData(input logic [11:0] addr);
        logic [31:0] d;
        logic [31:0] ones;
        int k;
        d = $urandom;
        if (addr >= 12'h3A0 && addr <= 12'h3A3) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) != 0) d[8*b+7] = 1'b0;
            end
        end else begin
            case ($urandom_range(0, 3))
                0: d = 32'($urandom_range(0, 1023));
                1: begin
                    k = $urandom_range(1, 31);
                    ones = 32'hFFFF_FFFF >> (32 - k);
                    d = (d & ~ones) | ones;
                    d[k] = 1'b0;
                end
                2: d = 32'hFFFF_FFFF;
                default: d = $urandom;
            endcase
        end
        return d;
    endfunction

    function automatic logic [31:0] randLookupAddr();
        case ($urandom_range(0, 2))
            0: return (mAddr[$urandom_range(0, NE - 1)] << 2) + 32'($urandom_range(0, 15)) - 32'd8;
            1: return 32'($urandom_range(0, 4095));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [11:0] wa;
        logic [11:0] ra;

        // Reset with a colliding write and lookup; everything must come up cleared.
        doReset();
        doReset();
        doRead(12'h3B0);

        applyStimulus(1'b0, 1'b1, 12'h3A0, 1'b0, 12'h0, 32'h0, 2'b11, 32'h1000_0000, 32'h1000_0000);
        checkOutput("dfltValid", {30'd0, lookup_valid_o}, 32'h3);
        checkOutput("dfltRwx", {26'd0, lookup_rwx_o}, {26'd0, 6'b111_111});
        checkOutput("dfltEntry", {22'd0, lookup_entry_o}, {22'd0, 10'h3FF});

        doWrite(12'h3B0, 32'h0400_01FF);
        doWrite(12'h3A0, 32'h0000_001B);
        doLookup(2'b11, 32'h1000_0000, 32'h1000_0FFF);
`ifdef CPU_PMP_NAPOT_EN
        checkOutput("napotRwx", {26'd0, lookup_rwx_o}, {26'd0, 6'b110_110});
        checkOutput("napotEntry", {22'd0, lookup_entry_o}, 32'd0);
`else
        checkOutput("napotOffRwx", {26'd0, lookup_rwx_o}, {26'd0, 6'b111_111});
`endif
        doLookup(2'b01, 32'h1000_1000, 32'h0);
        checkOutput("napotEdgeRwx", {29'd0, lookup_rwx_o[2:0]}, 32'd7);

        doWrite(12'h3B0, 32'h0000_0400);
        doWrite(12'h3B1, 32'h0000_0800);
        doWrite(12'h3A0, 32'h0000_8D00);
        doLookup(2'b11, 32'h0000_1000, 32'h0000_2000);
        checkOutput("torRwx", {29'd0, lookup_rwx_o[2:0]}, 32'b101);
        checkOutput("torEntry", {27'd0, lookup_entry_o[4:0]}, 32'd1);
        checkOutput("torTopEntry", {27'd0, lookup_entry_o[9:5]}, 32'h1F);
        doWrite(12'h3B0, 32'h0000_0123);
        doWrite(12'h3B1, 32'h0000_0456);
        doWrite(12'h3A0, 32'h0000_0000);
        doRead(12'h3B0);
        checkOutput("lockAddr0", read_data_o, 32'h0000_0400);
        doRead(12'h3B1);
        checkOutput("lockAddr1", read_data_o, 32'h0000_0800);
        doRead(12'h3A0);
        checkOutput("lockCfg1", read_data_o, 32'h0000_8D00);

        doWrite(12'h3A1, 32'h0000_0002);
        doRead(12'h3A1);
        checkOutput("wOnly", read_data_o, 32'h0);

        // Unimplemented entries 14 and 15 must ignore writes and read zero.
        doWrite(12'h3A3, 32'h0707_0707);
        doRead(12'h3A3);
        checkOutput("cfgUnimpl", read_data_o, 32'h0000_0707);
        doWrite(12'h3BE, 32'h1234_5678);
        doRead(12'h3BE);

        doReset();
        doWrite(12'h3B0, 32'h0400_0000);
        applyStimulus(1'b0, 1'b0, 12'h0, 1'b1, 12'h3A0, 32'h0000_0011, 2'b11, 32'h1000_0000, 32'h1000_0000);
        checkOutput("oldCfgEntry", {27'd0, lookup_entry_o[4:0]}, 32'h1F);
        doLookup(2'b11, 32'h1000_0000, 32'h1000_0000);
        checkOutput("newCfgRwx", {29'd0, lookup_rwx_o[2:0]}, 32'b100);

        doWrite(12'h3B2, 32'h3FC0_0001);
        doWrite(12'h3B3, 32'h3FC0_0010);
        doWrite(12'h3A0, 32'h0C13_0011);
        doLookup(2'b11, 32'hFF00_0004, 32'hFF00_0008);
        checkOutput("overlapEntry", {27'd0, lookup_entry_o[4:0]}, 32'd2);
        checkOutput("overlapRwx", {29'd0, lookup_rwx_o[2:0]}, 32'b110);
        checkOutput("torOnlyEntry", {27'd0, lookup_entry_o[9:5]}, 32'd3);
        applyStimulus(1'b1, 1'b0, 12'h0, 1'b0, 12'h0, 32'h0, 2'b11, 32'hFF00_0004, 32'hFF00_0008);
        checkOutput("rstFlight", {30'd0, lookup_valid_o}, 32'd0);

        doWrite(12'h3A0, 32'h0000_0018);
        doRead(12'h3A0);
`ifndef CPU_PMP_NAPOT_EN
        checkOutput("napotDisabled", read_data_o, 32'h0);
`endif

        for (int n = 0; n < 800; n++) begin
            if (n % 160 == 0) begin
                doReset();
            end
            wa = randCsrAddr();
            ra = randCsrAddr();
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa,
                          randWriteData(wa), 2'($urandom_range(0, 3)), randLookupAddr(), randLookupAddr());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
